tcdm_resp_reorder: RTL and testbench
====================================

// Module: tcdm_resp_reorder
// PURPOSE
// - Reorder buffer between a tile master port and the TCDM interconnect.
// - Tags each issued request with a meta ID and accepts responses in any order.
// - Returns response data to the master strictly in issue order.
// - Next generation of the per-tile TCDM meta_id handling: depth, data width and ID width are parametrised.
// - Adds an out-of-order response path and a sticky protocol-error flag.
// PARAMETERS
// - NumEntries   4   outstanding requests; power of two, >= 2
// - DataWidth    32  response payload width (mempool_pkg::DataWidth)
// - MetaIdWidth  5   tag width (snitch_pkg::MetaIdWidth); must be >= $clog2(NumEntries)
// PORTS
// - clk_i        in   1            clock
// - rst_i        in   1            asynchronous reset, active-high
// - req_valid_i  in   1            master wants to issue a request
// - req_ready_o  out  1            entry free; allocation fires when req_valid_i && req_ready_o
// - req_id_o     out  MetaIdWidth  tag for this request = tail index, zero-extended
// - resp_valid_i in   1            response from interconnect; always accepted, no ready
// - resp_id_i    in   MetaIdWidth  tag of the arriving response
// - resp_data_i  in   DataWidth    response payload
// - out_valid_o  out  1            head entry allocated and filled
// - out_ready_i  in   1            master accepts; release when out_valid_o && out_ready_i
// - out_data_o   out  DataWidth    payload of the head entry
// - full_o       out  1            count == NumEntries
// - empty_o      out  1            count == 0
// - err_o        out  1            sticky: response hit an unallocated or already-filled entry
// - stall_cnt_o  out  32           only with TCDM_ROB_STALL_CNT_EN; see CONFIGURATION
// BEHAVIOUR
// - State registers: head and tail pointers ($clog2(NumEntries) bits, natural wrap).
// - Count register is $clog2(NumEntries)+1 bits.
// - Per-entry state: alloc bit, filled bit, DataWidth data register.
// - Reset values:
//   - All pointers, count, alloc/filled bits and err = 0. Data registers are not reset.
//   - Outputs after reset: req_ready_o=1, req_id_o=0, out_valid_o=0, full_o=0, empty_o=1, err_o=0, stall_cnt_o=0.
// - Allocate (fire): alloc[tail] <= 1, filled[tail] <= 0, tail++, count++.
// - req_ready_o = !full_o, computed from current state only. A same-cycle release does not free a slot in that cycle.
// - Response:
//   - If resp_valid_i && alloc[id] && !filled[id] (id = resp_id_i low bits): data[id] <= resp_data_i, filled[id] <= 1.
//   - Otherwise the response is dropped and err <= 1.
//   - Upper tag bits above $clog2(NumEntries) must be 0. A nonzero upper bit is also dropped and sets err.
// - Output path:
//   - out_valid_o = alloc[head] && filled[head]; out_data_o = data[head]. Both are combinational from registers.
//   - Minimum latency: response in cycle N gives out_valid_o in cycle N+1. There is no bypass from resp_* to out_*.
//   - Release: alloc[head] <= 0, filled[head] <= 0, head++, count--.
// - Simultaneous events:
//   - Allocate and release in the same cycle: count unchanged, both pointers advance.
//   - Response to the head entry in the same cycle as a release of a different entry: impossible, because head is unique.
//   - Response targeting the tail entry being allocated in the same cycle: err, since the entry is not yet allocated.
//   - Several cycles with out_valid_o=1 and out_ready_i=0: out_data_o holds stable. out_valid_o must not drop.
// - err_o clears only on reset.
// - Reset mid-operation: all outstanding entries are discarded. Late responses after reset set err_o.
// CONFIGURATION
// - TCDM_ROB_STALL_CNT_EN defined:
//   - stall_cnt_o is a 32-bit counter, reset 0.
//   - Increments each cycle where count != 0 && !out_valid_o && any filled bit is set (head-of-line blocking).
//   - Saturates at 2^32-1.
// - TCDM_ROB_STALL_CNT_EN undefined: the stall_cnt_o port and its counter are absent.
// TESTING (NumEntries=4, DataWidth=32, MetaIdWidth=5)
// - In-order flow:
//   - Stimulus: issue 2 requests (tags 0, 1); respond tag0=0xA, then tag1=0xB; out_ready_i=1.
//   - Expected: out_data_o 0xA then 0xB, one cycle after each response; empty_o=1 at end.
// - Reverse order:
//   - Stimulus: issue 4 requests; respond tags 3, 2, 1, 0 with 0x3, 0x2, 0x1, 0x0.
//   - Expected: full_o=1 and req_ready_o=0 after the 4th issue; no out_valid_o until tag0 arrives; then 0x0, 0x1, 0x2, 0x3 on consecutive cycles.
// - Wrap-around:
//   - Stimulus: run 10 issue/respond/release rounds.
//   - Expected: req_id_o sequence 0, 1, 2, 3, 0, 1, ...; data intact; count never exceeds 4.
// - Full with concurrent release:
//   - Stimulus: with 4 outstanding and the head filled, drive out_ready_i=1 and req_valid_i=1.
//   - Expected: no allocation that cycle; req_ready_o=1 on the next cycle.
// - Error:
//   - Stimulus: send a response to tag 2 while empty; separately, send a duplicate response to a filled tag.
//   - Expected: err_o=1 and stays 1; stored data unchanged; count unchanged.
// - Stall counter / reset:
//   - Stimulus: with TCDM_ROB_STALL_CNT_EN, 2 outstanding, tag1 filled and tag0 pending for 5 cycles.
//   - Expected: stall_cnt_o=5.
//   - Stimulus: assert rst_i mid-flow.
//   - Expected: empty_o=1, err_o=0, stall_cnt_o=0 immediately.

Source files
------------

// File: rtl/tcdm_resp_reorder.sv
// rtl/tcdm_resp_reorder.sv - reorder buffer returning TCDM responses in issue order (option: TCDM_ROB_STALL_CNT_EN)
module tcdm_resp_reorder #(
  parameter int unsigned NumEntries  = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MetaIdWidth = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [MetaIdWidth-1:0] req_id_o,
  input  logic                   resp_valid_i,
  input  logic [MetaIdWidth-1:0] resp_id_i,
  input  logic [DataWidth-1:0]   resp_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_data_o,
  output logic                   full_o,
  output logic                   empty_o,
`ifdef TCDM_ROB_STALL_CNT_EN
  output logic [31:0]            stall_cnt_o,
`endif
  output logic                   err_o
);

  localparam int unsigned IdxW = $clog2(NumEntries);
  localparam int unsigned CntW = IdxW + 1;

  logic [IdxW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [NumEntries-1:0] alloc_q, alloc_d, filled_q, filled_d;
  logic                  err_q, err_d;
  logic [DataWidth-1:0]  data_q [NumEntries];

  logic            req_fire, rel_fire, resp_ok, upper_ok;
  logic [IdxW-1:0] resp_idx;

  // Handshakes and response acceptance, all decided from registered state
  always_comb begin
    full_o      = (count_q == CntW'(NumEntries));
    empty_o     = (count_q == '0);
    req_ready_o = !full_o;
    req_id_o    = MetaIdWidth'(tail_q);
    out_valid_o = alloc_q[head_q] && filled_q[head_q];
    out_data_o  = data_q[head_q];
    err_o       = err_q;
    req_fire    = req_valid_i && req_ready_o;
    rel_fire    = out_valid_o && out_ready_i;
    resp_idx    = resp_id_i[IdxW-1:0];
    // Tag bits above the index range must be zero, otherwise the tag names no entry
    upper_ok    = ((resp_id_i >> IdxW) == '0);
    resp_ok     = resp_valid_i && upper_ok && alloc_q[resp_idx] && !filled_q[resp_idx];
  end

  // Next-state for pointers, count, entry flags and the sticky error
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    alloc_d  = alloc_q;
    filled_d = filled_q;
    err_d    = err_q;
    if (rel_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + IdxW'(1);
    end
    if (resp_valid_i) begin
      if (resp_ok) filled_d[resp_idx] = 1'b1;
      else         err_d = 1'b1;
    end
    // The tail entry is never allocated when it fires, so a same-cycle response to it already erred
    if (req_fire) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + IdxW'(1);
    end
    case ({req_fire, rel_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

  // Payload storage; contents are only meaningful while the filled bit is set
  always_ff @(posedge clk_i) begin
    if (resp_ok) data_q[resp_idx] <= resp_data_i;
  end

`ifdef TCDM_ROB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count head-of-line blocking: work is waiting but the head has not returned yet
  always_comb begin
    stall_d = stall_q;
    if ((count_q != '0) && !out_valid_o && (|filled_q) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_tcdm_resp_reorder.sv
// tb/tb_tcdm_resp_reorder.sv - directed self-checking bench for tcdm_resp_reorder
module tb_tcdm_resp_reorder;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_id_o;
  logic        resp_valid_i;
  logic [4:0]  resp_id_i;
  logic [31:0] resp_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        full_o;
  logic        empty_o;
  logic        err_o;
`ifdef TCDM_ROB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  tcdm_resp_reorder #(.NumEntries(4), .DataWidth(32), .MetaIdWidth(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_o(req_id_o),
    .resp_valid_i(resp_valid_i), .resp_id_i(resp_id_i), .resp_data_i(resp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .full_o(full_o), .empty_o(empty_o),
`ifdef TCDM_ROB_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i  = 1'b0;
    resp_valid_i = 1'b0;
    resp_id_i    = '0;
    resp_data_i  = '0;
    out_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic respond(input logic [4:0] id, input logic [31:0] d);
    resp_valid_i = 1'b1;
    resp_id_i    = id;
    resp_data_i  = d;
    step();
    resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0h exp 1", req_ready_o); end
    checks++; if (req_id_o !== 5'd0) begin errors++; $display("FAIL reset_req_id got %0h exp 0", req_id_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", full_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", empty_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_o); end
`ifdef TCDM_ROB_STALL_CNT_EN
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall_cnt_o); end
`endif
  endtask

  task automatic test_in_order();
    do_reset();
    req_valid_i = 1'b1;
    checks++; if (req_id_o !== 5'd0) begin errors++; $display("FAIL inorder_id0 got %0h exp 0", req_id_o); end
    step();
    checks++; if (req_id_o !== 5'd1) begin errors++; $display("FAIL inorder_id1 got %0h exp 1", req_id_o); end
    step();
    req_valid_i  = 1'b0;
    resp_valid_i = 1'b1; resp_id_i = 5'd0; resp_data_i = 32'hA;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL inorder_no_bypass got %0h exp 0", out_valid_o); end
    step();
    resp_id_i = 5'd1; resp_data_i = 32'hB; out_ready_i = 1'b1;
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hA) begin errors++; $display("FAIL inorder_first got v=%0h d=%0h exp v=1 d=a", out_valid_o, out_data_o); end
    step();
    resp_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hB) begin errors++; $display("FAIL inorder_second got v=%0h d=%0h exp v=1 d=b", out_valid_o, out_data_o); end
    step();
    out_ready_i = 1'b0;
    checks++; if (empty_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL inorder_empty got e=%0h v=%0h exp e=1 v=0", empty_o, out_valid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL inorder_err got %0h exp 0", err_o); end
  endtask

  task automatic test_reverse();
    do_reset();
    req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_id_o !== 5'(i)) begin errors++; $display("FAIL reverse_id got %0h exp %0h", req_id_o, i); end
      step();
    end
    checks++; if (full_o !== 1'b1 || req_ready_o !== 1'b0) begin errors++; $display("FAIL reverse_full got f=%0h r=%0h exp f=1 r=0", full_o, req_ready_o); end
    req_valid_i = 1'b0;
    for (int t = 3; t >= 1; t--) begin
      respond(5'(t), 32'(t));
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reverse_hold tag=%0d got %0h exp 0", t, out_valid_o); end
    end
    respond(5'd0, 32'h0);
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'(k)) begin errors++; $display("FAIL reverse_out got v=%0h d=%0h exp v=1 d=%0h", out_valid_o, out_data_o, k); end
      step();
    end
    out_ready_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reverse_empty got %0h exp 1", empty_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid_i = 1'b1;
      checks++; if (req_id_o !== 5'(i % 4)) begin errors++; $display("FAIL wrap_id round=%0d got %0h exp %0h", i, req_id_o, i % 4); end
      step();
      req_valid_i = 1'b0;
      respond(5'(i % 4), 32'h100 + 32'(i));
      out_ready_i = 1'b1;
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h100 + 32'(i)) begin errors++; $display("FAIL wrap_data round=%0d got v=%0h d=%0h exp v=1 d=%0h", i, out_valid_o, out_data_o, 32'h100 + i); end
      step();
      out_ready_i = 1'b0;
      checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL wrap_empty round=%0d got e=%0h f=%0h exp e=1 f=0", i, empty_o, full_o); end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL wrap_err got %0h exp 0", err_o); end
  endtask

  task automatic test_full_concurrent();
    do_reset();
    req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req_valid_i = 1'b0;
    respond(5'd0, 32'h55);
    req_valid_i = 1'b1;
    out_ready_i = 1'b1;
    checks++; if (req_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== 32'h55) begin errors++; $display("FAIL fullrel_pre got r=%0h v=%0h d=%0h exp r=0 v=1 d=55", req_ready_o, out_valid_o, out_data_o); end
    step();
    req_valid_i = 1'b0;
    out_ready_i = 1'b0;
    checks++; if (req_ready_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL fullrel_ready got r=%0h f=%0h exp r=1 f=0", req_ready_o, full_o); end
    checks++; if (req_id_o !== 5'd0) begin errors++; $display("FAIL fullrel_noalloc got %0h exp 0", req_id_o); end
    checks++; if (out_valid_o !== 1'b0 || empty_o !== 1'b0) begin errors++; $display("FAIL fullrel_state got v=%0h e=%0h exp v=0 e=0", out_valid_o, empty_o); end
  endtask

  task automatic test_error();
    do_reset();
    respond(5'd2, 32'h77);
    checks++; if (err_o !== 1'b1 || empty_o !== 1'b1) begin errors++; $display("FAIL err_unalloc got err=%0h e=%0h exp err=1 e=1", err_o, empty_o); end
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    respond(5'd0, 32'h11);
    respond(5'd0, 32'h99);
    step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %0h exp 1", err_o); end
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h11) begin errors++; $display("FAIL err_dup_data got v=%0h d=%0h exp v=1 d=11", out_valid_o, out_data_o); end
    checks++; if (empty_o !== 1'b0 || full_o !== 1'b0 || req_id_o !== 5'd1) begin errors++; $display("FAIL err_count got e=%0h f=%0h id=%0h exp e=0 f=0 id=1", empty_o, full_o, req_id_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %0h exp 0", err_o); end
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    respond(5'b00100, 32'h22);
    checks++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL err_upper got err=%0h v=%0h exp err=1 v=0", err_o, out_valid_o); end
    do_reset();
    req_valid_i  = 1'b1;
    resp_valid_i = 1'b1; resp_id_i = 5'd0; resp_data_i = 32'h33;
    step();
    idle_inputs();
    checks++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL err_tail_same got err=%0h v=%0h exp err=1 v=0", err_o, out_valid_o); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    req_valid_i = 1'b1;
    step();
    step();
    req_valid_i = 1'b0;
    respond(5'd1, 32'hBB);
    for (int i = 0; i < 5; i++) step();
`ifdef TCDM_ROB_STALL_CNT_EN
    checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL stall_count got %0d exp 5", stall_cnt_o); end
`endif
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stall_hol got %0h exp 0", out_valid_o); end
    respond(5'd3, 32'hCC);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL stall_pre_err got %0h exp 1", err_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (empty_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL midreset got e=%0h err=%0h exp e=1 err=0", empty_o, err_o); end
`ifdef TCDM_ROB_STALL_CNT_EN
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL midreset_stall got %0d exp 0", stall_cnt_o); end
`endif
    step();
    rst_i = 1'b0;
    step();
    respond(5'd0, 32'hDD);
    checks++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL late_resp got err=%0h v=%0h exp err=1 v=0", err_o, out_valid_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_in_order();
    test_reverse();
    test_wrap();
    test_full_concurrent();
    test_error();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
